// File: rtl/agg_src_arbiter.sv
// rtl/agg_src_arbiter.sv - round-robin sender arbiter feeding one aggregator port
// Grants one source per aggregated word and applies fetch-width changes only between bursts.
module agg_src_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SRC     = 4,
    parameter int FETCH_WIDTH = 2,
    parameter int FW_BITS     = 3,
    localparam int GW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_empty_n,
    output logic [NUM_SRC-1:0]            src_deq,
    output logic [DATA_WIDTH-1:0]         agg_data,
    output logic                          agg_empty_n,
    input  logic                          agg_deq,
    input  logic [FW_BITS-1:0]            cfg_fetch_width,
    input  logic                          cfg_change,
    output logic                          agg_change_fetch_width,
    output logic [FW_BITS-1:0]            agg_fetch_width,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST    = 2'd1,
        RECONFIG = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [GW-1:0]      rr_ptr;
    logic [GW-1:0]      pick;
    logic [GW-1:0]      cand;
    logic               pick_vld;
    logic [FW_BITS-1:0] beat_cnt;
    logic [FW_BITS-1:0] shadow_fw;
    logic [FW_BITS-1:0] cfg_clamped;
    logic               pending;
    logic               cur_avail;
    logic               eff_deq;
    logic               burst_done;

    always_comb begin
        cfg_clamped = cfg_fetch_width;
        if (cfg_fetch_width == '0) begin
            cfg_clamped = FW_BITS'(1);
        end else if (cfg_fetch_width > FW_BITS'(FETCH_WIDTH)) begin
            cfg_clamped = FW_BITS'(FETCH_WIDTH);
        end
    end

    // Walk offsets from farthest to nearest so the nearest candidate after rr_ptr wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = GW'((int'(rr_ptr) + k) % NUM_SRC);
            if (src_empty_n[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign agg_data   = src_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign cur_avail  = src_empty_n[grant_id];
    assign eff_deq    = (state == BURST) && agg_deq && cur_avail;
    assign burst_done = eff_deq && (beat_cnt == agg_fetch_width - FW_BITS'(1));

    always_comb begin
        state_nxt              = state;
        agg_empty_n            = 1'b0;
        src_deq                = '0;
        agg_change_fetch_width = 1'b0;
        busy                   = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nxt = RECONFIG;
                end else if (pick_vld) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                busy              = 1'b1;
                agg_empty_n       = cur_avail;
                src_deq[grant_id] = eff_deq;
                if (burst_done) begin
                    state_nxt = IDLE;
                end
            end
            RECONFIG: begin
                busy                   = 1'b1;
                agg_change_fetch_width = 1'b1;
                state_nxt              = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            grant_id        <= '0;
            rr_ptr          <= GW'(NUM_SRC - 1);
            beat_cnt        <= '0;
            agg_fetch_width <= FW_BITS'(FETCH_WIDTH);
            shadow_fw       <= FW_BITS'(FETCH_WIDTH);
            pending         <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && !pending && pick_vld) begin
                grant_id <= pick;
                rr_ptr   <= pick;
                beat_cnt <= '0;
            end else if (eff_deq) begin
                beat_cnt <= beat_cnt + FW_BITS'(1);
            end
            // A request arriving on the entry cycle bypasses the shadow so the last value wins.
            if ((state == IDLE) && pending) begin
                agg_fetch_width <= cfg_change ? cfg_clamped : shadow_fw;
            end
            if (cfg_change) begin
                pending   <= 1'b1;
                shadow_fw <= cfg_clamped;
            end else if (state == RECONFIG) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
